// File: rtl/pc_stack_unit.sv
// Program-counter unit for mycpu: PC register, jump-condition decode and a
// hardware return-address stack with sticky overflow/underflow flags.
module pc_stack_unit #(
  parameter int N = 16,
  parameter int DEPTH = 8,
  parameter logic [N-1:0] RST_VEC = '0,
  localparam int SP_W = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [2:0]      jump,
  input  logic            zero,
  input  logic            neg,
  input  logic [N-1:0]    target,
  input  logic            call,
  input  logic            ret,
  input  logic            clr_err,
  output logic [N-1:0]    out,
  output logic [SP_W-1:0] sp,
  output logic            full,
  output logic            empty,
  output logic            overflow,
  output logic            underflow,
  output logic            redirect
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  function automatic logic jump_take(input logic [2:0] code, input logic z,
                                     input logic n);
    logic t;
    case (code)
      3'b000:  t = 1'b0;
      3'b001:  t = !z && !n;
      3'b010:  t = z;
      3'b011:  t = !n;
      3'b100:  t = n;
      3'b101:  t = !z;
      3'b110:  t = z || n;
      default: t = 1'b1;
    endcase
    return t;
  endfunction

  function automatic logic [N-1:0] pc_incr(input logic [N-1:0] pc);
    return pc + N'(1);
  endfunction

  logic [N-1:0]     stack [DEPTH];
  logic [N-1:0]     pc_inc;
  logic [N-1:0]     stack_top;
  logic [IDX_W-1:0] top_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             take;
  logic             push;
  logic [N-1:0]     out_nxt;
  logic [SP_W-1:0]  sp_nxt;
  logic             ovf_nxt;
  logic             unf_nxt;
  logic             redir_nxt;

  assign full      = (sp == SP_W'(DEPTH));
  assign empty     = (sp == '0);
  assign pc_inc    = pc_incr(out);
  assign take      = jump_take(jump, zero, neg);
  assign top_idx   = IDX_W'(sp - SP_W'(1));
  assign wr_idx    = IDX_W'(sp);
  assign stack_top = stack[top_idx];

  // Next-state decode: ret > call > conditional jump > sequential
  always_comb begin
    out_nxt   = out;
    sp_nxt    = sp;
    ovf_nxt   = overflow;
    unf_nxt   = underflow;
    redir_nxt = 1'b0;
    push      = 1'b0;
    if (en) begin
      // clear first so a same-cycle error event below takes precedence
      if (clr_err) begin
        ovf_nxt = 1'b0;
        unf_nxt = 1'b0;
      end
      if (ret) begin
        if (!empty) begin
          out_nxt   = stack_top;
          sp_nxt    = sp - SP_W'(1);
          redir_nxt = 1'b1;
        end else begin
          unf_nxt = 1'b1;
          out_nxt = pc_inc;
        end
      end else if (call) begin
        if (!full) begin
          push   = 1'b1;
          sp_nxt = sp + SP_W'(1);
        end else begin
          ovf_nxt = 1'b1;
        end
        out_nxt   = target;
        redir_nxt = 1'b1;
      end else if (take) begin
        out_nxt   = target;
        redir_nxt = 1'b1;
      end else begin
        out_nxt = pc_inc;
      end
    end
  end

  // State register stage
  always_ff @(posedge clk) begin
    if (!rst) begin
      out       <= RST_VEC;
      sp        <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      redirect  <= 1'b0;
    end else begin
      out       <= out_nxt;
      sp        <= sp_nxt;
      overflow  <= ovf_nxt;
      underflow <= unf_nxt;
      redirect  <= redir_nxt;
    end
  end

  // Stack storage carries no reset; occupancy alone defines validity
  always_ff @(posedge clk) begin
    if (rst && push) begin
      stack[wr_idx] <= pc_inc;
    end
  end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit: a queue-based reference model predicts
// every cycle's outputs, which are popped and checked after each edge.
module tb_pc_stack_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [2:0]  jump = 3'b000;
  logic        zero = 1'b0;
  logic        neg = 1'b0;
  logic [15:0] target = 16'h0000;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic        clr_err = 1'b0;
  logic [15:0] out;
  logic [3:0]  sp;
  logic        full, empty, overflow, underflow, redirect;

  int errors = 0;
  int checks = 0;

  pc_stack_unit #(.N(16), .DEPTH(8), .RST_VEC(16'h0000)) dut (
    .clk(clk), .rst(rst), .en(en), .jump(jump), .zero(zero), .neg(neg),
    .target(target), .call(call), .ret(ret), .clr_err(clr_err),
    .out(out), .sp(sp), .full(full), .empty(empty), .overflow(overflow),
    .underflow(underflow), .redirect(redirect)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    string       tag;
    logic [15:0] out;
    logic [3:0]  sp;
    logic        full, empty, ovf, unf, red;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m_stk[$];
  logic [15:0] m_out = 16'h0000;
  logic        m_ovf = 1'b0, m_unf = 1'b0, m_red = 1'b0;

  function automatic logic take_ref(input logic [2:0] j, input logic z, input logic n);
    case (j)
      3'd0: return 1'b0;
      3'd1: return (z == 1'b0) && (n == 1'b0);
      3'd2: return z == 1'b1;
      3'd3: return n == 1'b0;
      3'd4: return n == 1'b1;
      3'd5: return z == 1'b0;
      3'd6: return (z == 1'b1) || (n == 1'b1);
      default: return 1'b1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag);
    exp_t e;
    e.tag = tag;
    e.out = m_out;
    e.sp = 4'(m_stk.size());
    e.full = (m_stk.size() == 8);
    e.empty = (m_stk.size() == 0);
    e.ovf = m_ovf;
    e.unf = m_unf;
    e.red = m_red;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".out"}, 32'(out), 32'(e.out));
    chk({e.tag, ".sp"}, 32'(sp), 32'(e.sp));
    chk({e.tag, ".full"}, 32'(full), 32'(e.full));
    chk({e.tag, ".empty"}, 32'(empty), 32'(e.empty));
    chk({e.tag, ".ovf"}, 32'(overflow), 32'(e.ovf));
    chk({e.tag, ".unf"}, 32'(underflow), 32'(e.unf));
    chk({e.tag, ".redir"}, 32'(redirect), 32'(e.red));
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0; en = 1'b1; call = 1'b1; jump = 3'b111; target = 16'hABCD;
    m_out = 16'h0000; m_stk.delete(); m_ovf = 0; m_unf = 0; m_red = 0;
    push_exp(tag);
    @(posedge clk); #1;
    pop_check();
    rst = 1'b1; call = 1'b0; jump = 3'b000;
  endtask

  task automatic step(input logic e, input logic [2:0] j, input logic z, input logic n,
                      input logic [15:0] t, input logic c, input logic r,
                      input logic ce, input string tag);
    en = e; jump = j; zero = z; neg = n; target = t; call = c; ret = r; clr_err = ce;
    if (!e) m_red = 0;
    else begin
      if (ce) begin m_ovf = 0; m_unf = 0; end
      if (r) begin
        if (m_stk.size() > 0) begin m_out = m_stk.pop_back(); m_red = 1; end
        else begin m_unf = 1; m_out = m_out + 16'd1; m_red = 0; end
      end else if (c) begin
        if (m_stk.size() < 8) m_stk.push_back(m_out + 16'd1);
        else m_ovf = 1;
        m_out = t; m_red = 1;
      end else if (take_ref(j, z, n)) begin
        m_out = t; m_red = 1;
      end else begin
        m_out = m_out + 16'd1; m_red = 0;
      end
    end
    push_exp(tag);
    @(posedge clk); #1;
    pop_check();
  endtask

  initial begin
    #1;
    do_reset("reset");
    chk("reset_out_const", 32'(out), 32'h0);

    for (int i = 0; i < 5; i++) step(1, 3'b000, 0, 0, 16'h0, 0, 0, 0, "seq");
    chk("seq5_const", 32'(out), 32'h5);

    step(1, 3'b111, 0, 0, 16'h0010, 0, 0, 0, "jmp10");
    step(1, 3'b001, 0, 0, 16'h0200, 0, 0, 0, "jgt_take");
    chk("jgt_take_const", 32'(out), 32'h0200);
    step(1, 3'b111, 0, 0, 16'h0010, 0, 0, 0, "jmp10b");
    step(1, 3'b001, 0, 1, 16'h0200, 0, 0, 0, "jgt_notake");
    chk("jgt_notake_const", 32'(out), 32'h0011);

    for (int code = 0; code < 8; code++)
      for (int f = 0; f < 4; f++)
        step(1, 3'(code), f[1], f[0], 16'h1000 + 16'(code * 16 + f), 0, 0, 0, "sweep");

    step(1, 3'b111, 0, 0, 16'h0005, 0, 0, 0, "jmp5");
    step(1, 3'b000, 0, 0, 16'h0100, 1, 0, 0, "call1");
    chk("call1_sp_const", 32'(sp), 32'd1);
    for (int i = 0; i < 3; i++) step(1, 3'b000, 0, 0, 16'h0, 0, 0, 0, "body");
    chk("body_const", 32'(out), 32'h0103);
    step(1, 3'b000, 0, 0, 16'h0, 0, 1, 0, "ret1");
    chk("ret1_const", 32'(out), 32'h0006);

    for (int i = 0; i < 9; i++)
      step(1, 3'b000, 0, 0, 16'h2000 + 16'(i * 16), 1, 0, 0, "nest_call");
    chk("ovf_target_const", 32'(out), 32'h2080);
    for (int i = 0; i < 8; i++) step(1, 3'b000, 0, 0, 16'h0, 0, 1, 0, "nest_ret");
    chk("lifo_last_const", 32'(out), 32'h0007);
    step(1, 3'b000, 0, 0, 16'h0, 0, 0, 1, "clr_ovf");

    step(1, 3'b111, 0, 0, 16'h0040, 0, 0, 0, "jmp40");
    step(1, 3'b000, 0, 0, 16'h0, 0, 1, 0, "unf_set");
    chk("unf_out_const", 32'(out), 32'h0041);
    step(0, 3'b000, 0, 0, 16'h0, 0, 0, 1, "clr_while_hold");
    step(1, 3'b000, 0, 0, 16'h0, 0, 0, 1, "unf_clr");
    step(1, 3'b000, 0, 0, 16'h0, 0, 1, 1, "unf_set_beats_clr");
    chk("set_wins_const", 32'(underflow), 32'd1);
    step(1, 3'b000, 0, 0, 16'h0, 0, 0, 1, "unf_clr2");

    step(1, 3'b111, 0, 0, 16'hFFFF, 0, 0, 0, "jmp_ffff");
    step(1, 3'b000, 0, 0, 16'h0, 0, 0, 0, "wrap");
    chk("wrap_const", 32'(out), 32'h0000);
    step(1, 3'b111, 0, 0, 16'hFFFF, 0, 0, 0, "jmp_ffff2");
    step(1, 3'b000, 0, 0, 16'h0300, 1, 0, 0, "call_wrap");
    step(1, 3'b000, 0, 0, 16'h0, 0, 1, 0, "ret_wrap");
    chk("ret_wrap_const", 32'(out), 32'h0000);

    step(1, 3'b111, 0, 0, 16'h0500, 0, 0, 0, "jmp500");
    step(0, 3'b111, 0, 0, 16'h0777, 1, 0, 0, "hold_call");
    step(0, 3'b111, 0, 0, 16'h0777, 0, 1, 0, "hold_ret");
    step(1, 3'b000, 0, 0, 16'h0600, 1, 0, 0, "call600");
    step(1, 3'b111, 0, 0, 16'h0900, 1, 1, 0, "call_ret_both");
    chk("both_const", 32'(out), 32'h0501);

    step(1, 3'b000, 0, 0, 16'h0A00, 1, 0, 0, "chain1");
    step(1, 3'b000, 0, 0, 16'h0B00, 1, 0, 0, "chain2");
    step(1, 3'b000, 0, 0, 16'h0, 0, 1, 1, "chain_ret");
    for (int i = 0; i < 9; i++)
      step(1, 3'b000, 0, 0, 16'h0C00 + 16'(i), 1, 0, 0, "chain_fill");
    do_reset("mid_reset");
    chk("mid_reset_sp_const", 32'(sp), 32'd0);
    step(1, 3'b000, 0, 0, 16'h0, 0, 1, 0, "post_reset_ret");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
- Parametrised program-counter unit for the mycpu core. Merges PC register, jump-condition decode and a hardware return-address stack.
- Supports conditional jumps on ALU zero/neg flags, CALL/RET with a DEPTH-entry LIFO, and stall (hold) cycles.
- Sticky overflow/underflow flags and a one-cycle redirect pulse for pipeline flush.

Parameters:
- N, 16, PC/address width in bits.
- DEPTH, 8, return-stack entries (>=2).
- RST_VEC, 0, PC value loaded on reset (N bits).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-low.
- en  in  1  instruction clock enable; 0 = hold all state.
- jump  in  3  C-instruction jump field.
- zero  in  1  ALU zero flag.
- neg  in  1  ALU negative flag.
- target  in  N  jump/call destination (A register).
- call  in  1  push return address, branch to target.
- ret  in  1  pop return address into PC.
- clr_err  in  1  clear sticky error flags.
- out  out  N  current PC.
- sp  out  $clog2(DEPTH+1)  stack occupancy, 0..DEPTH.
- full  out  1  sp == DEPTH (combinational from sp).
- empty  out  1  sp == 0 (combinational from sp).
- overflow  out  1  sticky: CALL attempted while full.
- underflow  out  1  sticky: RET attempted while empty.
- redirect  out  1  registered; 1 for the cycle after a non-sequential PC update.

Behaviour:
- Reset (rst=0 at posedge): out=RST_VEC, sp=0, overflow=0, underflow=0, redirect=0. Stack RAM contents don't care. Reset overrides en and all other inputs.
- Jump condition take:
  - 000 never.
  - 001 JGT = !zero & !neg.
  - 010 JEQ = zero.
  - 011 JGE = !neg.
  - 100 JLT = neg.
  - 101 JNE = !zero.
  - 110 JLE = zero | neg.
  - 111 JMP always.
  - Flags are used as given; zero=neg=1 is not filtered.
- en=0: out, sp, stack and error flags hold. redirect<=0. clr_err is ignored.
- en=1, priority per cycle:
  1. ret. If !empty: out<=stack[sp-1], sp<=sp-1, redirect<=1. If empty: underflow<=1, out<=out+1, redirect<=0.
  2. call (ret=0). If !full: stack[sp]<=out+1, sp<=sp+1. If full: overflow<=1, no push, sp unchanged. In both cases out<=target, redirect<=1. jump is ignored.
  3. take (no call/ret): out<=target, redirect<=1.
  4. Otherwise: out<=out+1, redirect<=0.
- Simultaneous call and ret: ret wins, call is dropped, no error flag.
- Arithmetic: out+1 and the pushed return address wrap modulo 2^N (all-ones -> 0).
- Latency: every update is visible on out the cycle after the sampling edge. The stack top is readable with zero-cycle latency (register array, no RAM read latency).
- Sticky flags: set on event, cleared by clr_err when en=1. If set and clear occur in the same cycle, set wins.
- Mid-operation reset: any pending state is discarded; the stack is logically emptied (sp=0).

Test Plan:
- Reset, then en=1 for 5 cycles with jump=000, call=ret=0 -> out 0,1,2,3,4,5, redirect=0 throughout, sp=0.
- out=0x0010, jump=001, zero=0/neg=0 -> out=target 0x0200 and redirect=1 next cycle. Repeat with neg=1 -> out=0x0011. Sweep all 8 codes x 4 flag combinations against the take table.
- call at out=0x0005, target=0x0100 -> out=0x0100, sp=1. Run 3 cycles to 0x0103, then ret -> out=0x0006, sp=0, redirect=1.
- DEPTH=8: perform 9 nested calls -> sp=8 and full=1 after the 8th. The 9th sets overflow=1 and still loads target, sp stays 8. Then 8 rets return the addresses in LIFO order.
- ret with sp=0 at out=0x0040 -> underflow=1, out=0x0041. clr_err=1 next cycle -> underflow=0. Assert ret-empty and clr_err in the same cycle -> underflow stays 1.
- N=16, out=0xFFFF, no branch -> out=0x0000. call at 0xFFFF pushes 0x0000. en=0 during call/jump -> no state change. rst=0 mid-call-chain -> out=RST_VEC, sp=0, flags 0.
